// File: rtl/mem_stage_pkg.sv
// Shared types and encodings for the MEM pipeline stage: bundle layouts,
// load-type and TLB-op encodings, and the stage FSM state type.
package mem_stage_pkg;

   localparam int MEM2WB_LEN  = 239;
   localparam int EXE2MEM_LEN = MEM2WB_LEN + 4;

   localparam logic [2:0] LD_NONE = 3'd0;
   localparam logic [2:0] LD_B    = 3'd1;
   localparam logic [2:0] LD_BU   = 3'd2;
   localparam logic [2:0] LD_H    = 3'd3;
   localparam logic [2:0] LD_HU   = 3'd4;
   localparam logic [2:0] LD_W    = 3'd5;

   localparam logic [2:0] TLB_OP_NONE = 3'd0;
   localparam logic [2:0] TLB_OP_SRCH = 3'd1;
   localparam logic [2:0] TLB_OP_RD   = 3'd2;
   localparam logic [2:0] TLB_OP_WR   = 3'd3;
   localparam logic [2:0] TLB_OP_FILL = 3'd4;
   localparam logic [2:0] TLB_OP_INV  = 3'd5;

   // aux is the bundle tail that MEM never interprets, only carries to WB.
   typedef struct packed {
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] rf_wdata;
      logic [31:0] pc;
      logic        csr_read;
      logic        csr_we;
      logic [13:0] csr_num;
      logic [31:0] csr_wmask;
      logic [31:0] csr_wvalue;
      logic [31:0] vaddr;
      logic        ex_valid;
      logic [5:0]  ecode;
      logic [8:0]  esubcode;
      logic        is_ertn;
      logic [2:0]  tlb_op;
      logic [4:0]  invtlb_op;
      logic [31:0] aux;
   } mem2wb_t;

   typedef struct packed {
      logic [2:0] ld_type;
      logic       mem_req_sent;
      mem2wb_t    wb;
   } exe2mem_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_HOLD
   } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Handshake and data bus around the MEM stage: EXE input side, WB output
// side, data-SRAM response, flush and the ID forwarding bundle.
interface mem_stage_if;
   import mem_stage_pkg::*;

   logic                   mem_allowin;
   logic                   exe_to_mem_valid;
   logic [EXE2MEM_LEN-1:0] exe_to_mem_zip;
   logic                   wb_allowin;
   logic                   mem_to_wb_valid;
   logic [MEM2WB_LEN-1:0]  mem_to_wb_zip;
   logic                   data_sram_data_ok;
   logic [31:0]            data_sram_rdata;
   logic                   wb_ex;
   logic                   mem_ex;
   logic [38:0]            mem_rf_zip;

   modport slave (
      output mem_allowin,
      input  exe_to_mem_valid,
      input  exe_to_mem_zip,
      input  wb_allowin,
      output mem_to_wb_valid,
      output mem_to_wb_zip,
      input  data_sram_data_ok,
      input  data_sram_rdata,
      input  wb_ex,
      output mem_ex,
      output mem_rf_zip
   );

   modport master (
      input  mem_allowin,
      output exe_to_mem_valid,
      output exe_to_mem_zip,
      output wb_allowin,
      input  mem_to_wb_valid,
      input  mem_to_wb_zip,
      output data_sram_data_ok,
      output data_sram_rdata,
      output wb_ex,
      input  mem_ex,
      input  mem_rf_zip
   );

endinterface

// File: rtl/mem_stage_load_align.sv
// Combinational load aligner: picks the byte/half lane from the low address
// bits and sign- or zero-extends it to 32 bits.
module load_align
   import mem_stage_pkg::*;
(
   input  logic [2:0]  ld_type,
   input  logic [1:0]  addr,
   input  logic [31:0] word,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[{addr, 3'b000} +: 8];
      half_sel = addr[1] ? word[31:16] : word[15:0];
      case (ld_type)
         LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
         LD_BU:   result = {24'd0, byte_sel};
         LD_H:    result = {{16{half_sel[15]}}, half_sel};
         LD_HU:   result = {16'd0, half_sel};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for the data-SRAM response, aligns load data and
// hands the bundle to WB. `define MEM_LOAD_FWD_EN to forward load data to ID early.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int TAG_W = 2
) (
   input logic         clk,
   input logic         reset,
   mem_stage_if.slave  bus
);

   localparam logic [TAG_W-1:0] CNT_MAX = '1;
   localparam logic [TAG_W-1:0] CNT_ONE = TAG_W'(1);

   mem_state_e       state;
   exe2mem_t         mem_zip;
   exe2mem_t         exe_zip;
   mem2wb_t          out_zip;
   logic [31:0]      ld_buf;
   logic             ld_buf_v;
   logic [TAG_W-1:0] discard_cnt;
   logic [TAG_W-1:0] discard_nxt;

   logic        mem_valid;
   logic        usable_ok;
   logic        mem_ready_go;
   logic        accept;
   logic        handoff;
   logic        disc_inc;
   logic        disc_dec;
   logic [31:0] ld_word;
   logic [31:0] aligned;
   logic [31:0] wb_wdata;
   logic        mem_block;
   logic [31:0] fwd_data;
   logic        rf_we_eff;

   assign exe_zip      = bus.exe_to_mem_zip;
   assign mem_valid    = (state != ST_IDLE);
   assign usable_ok    = bus.data_sram_data_ok && (discard_cnt == '0);
   assign mem_ready_go = (state == ST_HOLD) || ((state == ST_WAIT) && usable_ok);
   assign handoff      = mem_valid && mem_ready_go && bus.wb_allowin;
   assign accept       = bus.mem_allowin && bus.exe_to_mem_valid && !bus.wb_ex;

   // Responses owed to flushed loads are counted so they can be dropped later.
   assign disc_inc = bus.wb_ex && (state == ST_WAIT) && !usable_ok;
   assign disc_dec = bus.data_sram_data_ok && (discard_cnt != '0);

   always_comb begin
      discard_nxt = discard_cnt;
      if (disc_inc && !disc_dec && (discard_cnt != CNT_MAX)) begin
         discard_nxt = discard_cnt + CNT_ONE;
      end else if (disc_dec && !disc_inc) begin
         discard_nxt = discard_cnt - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         mem_zip     <= '0;
         ld_buf      <= '0;
         ld_buf_v    <= 1'b0;
         discard_cnt <= '0;
      end else begin
         discard_cnt <= discard_nxt;
         if (bus.wb_ex) begin
            state    <= ST_IDLE;
            ld_buf_v <= 1'b0;
         end else if (accept) begin
            state    <= exe_zip.mem_req_sent ? ST_WAIT : ST_HOLD;
            mem_zip  <= exe_zip;
            ld_buf_v <= 1'b0;
         end else if (handoff) begin
            state    <= ST_IDLE;
            ld_buf_v <= 1'b0;
         end else if ((state == ST_WAIT) && usable_ok) begin
            state    <= ST_HOLD;
            ld_buf   <= bus.data_sram_rdata;
            ld_buf_v <= 1'b1;
         end
      end
   end

   // An overflow would let a stale response be mistaken for live load data.
   assert property (@(posedge clk) disable iff (reset)
      !(disc_inc && !disc_dec && (discard_cnt == CNT_MAX)));

   assign ld_word = ld_buf_v ? ld_buf : bus.data_sram_rdata;

   load_align u_load_align (
      .ld_type (mem_zip.ld_type),
      .addr    (mem_zip.wb.vaddr[1:0]),
      .word    (ld_word),
      .result  (aligned)
   );

   assign wb_wdata = (mem_zip.ld_type == LD_NONE) ? mem_zip.wb.rf_wdata : aligned;

   always_comb begin
      out_zip          = mem_zip.wb;
      out_zip.rf_wdata = wb_wdata;
      if (mem_zip.wb.ex_valid) begin
         out_zip.rf_we = 1'b0;
      end
   end

`ifdef MEM_LOAD_FWD_EN
   assign mem_block = mem_valid && (mem_zip.wb.csr_read ||
                      ((mem_zip.ld_type != LD_NONE) && !mem_ready_go));
   assign fwd_data  = wb_wdata;
`else
   assign mem_block = mem_valid && (mem_zip.wb.csr_read || (mem_zip.ld_type != LD_NONE));
   assign fwd_data  = mem_zip.wb.rf_wdata;
`endif

   assign rf_we_eff = mem_valid && mem_zip.wb.rf_we && !mem_zip.wb.ex_valid;

   assign bus.mem_allowin     = !mem_valid || (mem_ready_go && bus.wb_allowin);
   assign bus.mem_to_wb_valid = mem_valid && mem_ready_go && !bus.wb_ex;
   assign bus.mem_to_wb_zip   = out_zip;
   assign bus.mem_ex          = mem_valid && (mem_zip.wb.ex_valid || mem_zip.wb.is_ertn);
   assign bus.mem_rf_zip      = {mem_block, rf_we_eff, mem_zip.wb.rf_waddr, fwd_data};

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: reset, load alignment, load
// buffering under WB backpressure, flush/discard, back-to-back ALU traffic.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   tests_run    = 0;
   int   tests_failed = 0;

`ifdef MEM_LOAD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   mem_stage_if bus ();

   mem_stage #(.TAG_W(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   mem2wb_t wbz;
   assign wbz = bus.mem_to_wb_zip;

   function automatic logic [EXE2MEM_LEN-1:0] make_zip(input logic [2:0] ld_type,
      input logic req, input logic [4:0] waddr, input logic [31:0] wdata,
      input logic [31:0] vaddr, input logic csr_read, input logic ex_valid);
      exe2mem_t z;
      z                 = '0;
      z.ld_type         = ld_type;
      z.mem_req_sent    = req;
      z.wb.rf_we        = 1'b1;
      z.wb.rf_waddr     = waddr;
      z.wb.rf_wdata     = wdata;
      z.wb.pc           = 32'h1c00_0100;
      z.wb.vaddr        = vaddr;
      z.wb.csr_read     = csr_read;
      z.wb.ex_valid     = ex_valid;
      z.wb.ecode        = ex_valid ? 6'h0b : 6'h00;
      return z;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.exe_to_mem_valid  = 1'b0;
      bus.exe_to_mem_zip    = '0;
      bus.wb_allowin        = 1'b1;
      bus.data_sram_data_ok = 1'b0;
      bus.data_sram_rdata   = '0;
      bus.wb_ex             = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      step();
      step();
      reset = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.mem_to_wb_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL rst_wb_valid: got %0b expected 0", bus.mem_to_wb_valid);
      end
      tests_run++;
      if (bus.mem_allowin !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL rst_allowin: got %0b expected 1", bus.mem_allowin);
      end
      tests_run++;
      if (bus.mem_ex !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL rst_mem_ex: got %0b expected 0", bus.mem_ex);
      end
      tests_run++;
      if (bus.mem_rf_zip !== 39'd0) begin
         tests_failed++;
         $display("[TB] FAIL rst_rf_zip: got %h expected 0", bus.mem_rf_zip);
      end
      tests_run++;
      if (bus.mem_to_wb_zip !== '0) begin
         tests_failed++;
         $display("[TB] FAIL rst_wb_zip: got %h expected 0", bus.mem_to_wb_zip);
      end
      step();
   endtask

   task automatic test_load_word();
      bus.exe_to_mem_valid = 1'b1;
      bus.exe_to_mem_zip   = make_zip(LD_W, 1'b1, 5'd5, 32'd0, 32'h0000_1000, 1'b0, 1'b0);
      step();
      bus.exe_to_mem_valid = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.mem_to_wb_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL ldw_wait_valid: got %0b expected 0", bus.mem_to_wb_valid);
      end
      tests_run++;
      if (bus.mem_rf_zip[38] !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL ldw_block_c1: got %0b expected 1", bus.mem_rf_zip[38]);
      end
      step();
      bus.data_sram_data_ok = 1'b1;
      bus.data_sram_rdata   = 32'hDEAD_BEEF;
      @(negedge clk);
      tests_run++;
      if (bus.mem_to_wb_valid !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL ldw_valid: got %0b expected 1", bus.mem_to_wb_valid);
      end
      tests_run++;
      if (wbz.rf_wdata !== 32'hDEAD_BEEF) begin
         tests_failed++;
         $display("[TB] FAIL ldw_data: got %h expected deadbeef", wbz.rf_wdata);
      end
      tests_run++;
      if (wbz.rf_waddr !== 5'd5 || wbz.rf_we !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL ldw_dest: got we=%0b addr=%0d expected we=1 addr=5", wbz.rf_we, wbz.rf_waddr);
      end
      tests_run++;
      if (bus.mem_rf_zip[38] !== !FWD) begin
         tests_failed++;
         $display("[TB] FAIL ldw_block_c2: got %0b expected %0b", bus.mem_rf_zip[38], !FWD);
      end
      tests_run++;
      if (bus.mem_rf_zip[31:0] !== (FWD ? 32'hDEAD_BEEF : 32'd0)) begin
         tests_failed++;
         $display("[TB] FAIL ldw_fwd: got %h expected %h", bus.mem_rf_zip[31:0], FWD ? 32'hDEAD_BEEF : 32'd0);
      end
      step();
      bus.data_sram_data_ok = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.mem_to_wb_valid !== 1'b0 || bus.mem_rf_zip[38] !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL ldw_after: got valid=%0b block=%0b expected 0/0", bus.mem_to_wb_valid, bus.mem_rf_zip[38]);
      end
      step();
   endtask

   task automatic test_load_align();
      logic [2:0]  t_type [5] = '{LD_B, LD_BU, LD_HU, LD_H, LD_B};
      logic [31:0] t_addr [5] = '{32'h1003, 32'h1003, 32'h1002, 32'h1000, 32'h1001};
      logic [31:0] t_data [5] = '{32'h8011_2233, 32'h8011_2233, 32'h8011_2233, 32'h1234_ABCD, 32'h0000_7F00};
      logic [31:0] t_exp  [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_8011, 32'hFFFF_ABCD, 32'h0000_007F};
      for (int i = 0; i < 5; i++) begin
         bus.exe_to_mem_valid = 1'b1;
         bus.exe_to_mem_zip   = make_zip(t_type[i], 1'b1, 5'd9, 32'd0, t_addr[i], 1'b0, 1'b0);
         step();
         bus.exe_to_mem_valid  = 1'b0;
         bus.data_sram_data_ok = 1'b1;
         bus.data_sram_rdata   = t_data[i];
         @(negedge clk);
         tests_run++;
         if (bus.mem_to_wb_valid !== 1'b1 || wbz.rf_wdata !== t_exp[i]) begin
            tests_failed++;
            $display("[TB] FAIL align_%0d: got valid=%0b data=%h expected valid=1 data=%h",
                     i, bus.mem_to_wb_valid, wbz.rf_wdata, t_exp[i]);
         end
         step();
         bus.data_sram_data_ok = 1'b0;
      end
   endtask

   task automatic test_ld_buf();
      bus.exe_to_mem_valid = 1'b1;
      bus.exe_to_mem_zip   = make_zip(LD_W, 1'b1, 5'd7, 32'd0, 32'h0000_2000, 1'b0, 1'b0);
      step();
      bus.exe_to_mem_valid  = 1'b0;
      bus.wb_allowin        = 1'b0;
      bus.data_sram_data_ok = 1'b1;
      bus.data_sram_rdata   = 32'hCAFE_F00D;
      @(negedge clk);
      tests_run++;
      if (bus.mem_to_wb_valid !== 1'b1 || bus.mem_allowin !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL buf_c1: got valid=%0b allowin=%0b expected 1/0", bus.mem_to_wb_valid, bus.mem_allowin);
      end
      step();
      bus.data_sram_data_ok = 1'b0;
      bus.data_sram_rdata   = 32'h1111_1111;
      @(negedge clk);
      tests_run++;
      if (wbz.rf_wdata !== 32'hCAFE_F00D || bus.mem_allowin !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL buf_c2: got data=%h allowin=%0b expected cafef00d/0", wbz.rf_wdata, bus.mem_allowin);
      end
      step();
      @(negedge clk);
      tests_run++;
      if (bus.mem_to_wb_valid !== 1'b1 || bus.mem_allowin !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL buf_c3: got valid=%0b allowin=%0b expected 1/0", bus.mem_to_wb_valid, bus.mem_allowin);
      end
      step();
      bus.wb_allowin = 1'b1;
      @(negedge clk);
      tests_run++;
      if (bus.mem_to_wb_valid !== 1'b1 || wbz.rf_wdata !== 32'hCAFE_F00D || bus.mem_allowin !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL buf_handoff: got valid=%0b data=%h allowin=%0b expected 1/cafef00d/1",
                  bus.mem_to_wb_valid, wbz.rf_wdata, bus.mem_allowin);
      end
      step();
      @(negedge clk);
      tests_run++;
      if (bus.mem_to_wb_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL buf_after: got %0b expected 0", bus.mem_to_wb_valid);
      end
      step();
   endtask

   task automatic test_flush();
      bus.exe_to_mem_valid = 1'b1;
      bus.exe_to_mem_zip   = make_zip(LD_NONE, 1'b0, 5'd2, 32'h0000_0042, 32'd0, 1'b0, 1'b0);
      step();
      bus.exe_to_mem_valid = 1'b0;
      bus.wb_ex            = 1'b1;
      @(negedge clk);
      tests_run++;
      if (bus.mem_to_wb_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL flush_hold_valid: got %0b expected 0", bus.mem_to_wb_valid);
      end
      step();
      bus.wb_ex            = 1'b0;
      bus.exe_to_mem_valid = 1'b1;
      bus.exe_to_mem_zip   = make_zip(LD_W, 1'b1, 5'd3, 32'd0, 32'h0000_3000, 1'b0, 1'b0);
      step();
      bus.exe_to_mem_valid = 1'b0;
      bus.wb_ex            = 1'b1;
      @(negedge clk);
      step();
      bus.wb_ex = 1'b0;
      @(negedge clk);
      tests_run++;
      if (dut.discard_cnt !== 2'd1 || bus.mem_allowin !== 1'b1 || bus.mem_rf_zip[38] !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL flush_state: got cnt=%0d allowin=%0b block=%0b expected 1/1/0",
                  dut.discard_cnt, bus.mem_allowin, bus.mem_rf_zip[38]);
      end
      bus.exe_to_mem_valid = 1'b1;
      bus.exe_to_mem_zip   = make_zip(LD_W, 1'b1, 5'd4, 32'd0, 32'h0000_3004, 1'b0, 1'b0);
      step();
      bus.exe_to_mem_valid  = 1'b0;
      bus.data_sram_data_ok = 1'b1;
      bus.data_sram_rdata   = 32'hBAD0_BAD0;
      @(negedge clk);
      tests_run++;
      if (bus.mem_to_wb_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL flush_orphan_dropped: got valid=%0b expected 0", bus.mem_to_wb_valid);
      end
      step();
      bus.data_sram_rdata = 32'h600D_F00D;
      @(negedge clk);
      tests_run++;
      if (dut.discard_cnt !== 2'd0) begin
         tests_failed++;
         $display("[TB] FAIL flush_cnt_dec: got %0d expected 0", dut.discard_cnt);
      end
      tests_run++;
      if (bus.mem_to_wb_valid !== 1'b1 || wbz.rf_wdata !== 32'h600D_F00D || wbz.rf_waddr !== 5'd4) begin
         tests_failed++;
         $display("[TB] FAIL flush_next_load: got valid=%0b data=%h addr=%0d expected 1/600df00d/4",
                  bus.mem_to_wb_valid, wbz.rf_wdata, wbz.rf_waddr);
      end
      step();
      bus.data_sram_data_ok = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] d [4] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
      for (int k = 0; k <= 4; k++) begin
         if (k < 4) begin
            bus.exe_to_mem_valid = 1'b1;
            bus.exe_to_mem_zip   = make_zip(LD_NONE, 1'b0, 5'(k + 1), d[k], 32'd0, (k == 3), (k == 2));
         end else begin
            bus.exe_to_mem_valid = 1'b0;
         end
         @(negedge clk);
         if (k > 0) begin
            tests_run++;
            if (bus.mem_to_wb_valid !== 1'b1 || wbz.rf_wdata !== d[k-1] || bus.mem_allowin !== 1'b1) begin
               tests_failed++;
               $display("[TB] FAIL b2b_%0d: got valid=%0b data=%h allowin=%0b expected 1/%h/1",
                        k - 1, bus.mem_to_wb_valid, wbz.rf_wdata, bus.mem_allowin, d[k-1]);
            end
            tests_run++;
            if (wbz.rf_we !== (k - 1 != 2) || bus.mem_ex !== (k - 1 == 2) || bus.mem_rf_zip[37] !== (k - 1 != 2)) begin
               tests_failed++;
               $display("[TB] FAIL b2b_ex_%0d: got we=%0b mem_ex=%0b we_eff=%0b expected %0b/%0b/%0b",
                        k - 1, wbz.rf_we, bus.mem_ex, bus.mem_rf_zip[37], (k - 1 != 2), (k - 1 == 2), (k - 1 != 2));
            end
            tests_run++;
            if (bus.mem_rf_zip[38] !== (k - 1 == 3)) begin
               tests_failed++;
               $display("[TB] FAIL b2b_block_%0d: got %0b expected %0b", k - 1, bus.mem_rf_zip[38], (k - 1 == 3));
            end
         end
         step();
      end
   endtask

   task automatic test_reset_in_wait();
      bus.exe_to_mem_valid = 1'b1;
      bus.exe_to_mem_zip   = make_zip(LD_W, 1'b1, 5'd6, 32'd0, 32'h0000_4000, 1'b0, 1'b0);
      step();
      bus.exe_to_mem_valid = 1'b0;
      bus.wb_ex            = 1'b1;
      step();
      bus.wb_ex            = 1'b0;
      bus.exe_to_mem_valid = 1'b1;
      bus.exe_to_mem_zip   = make_zip(LD_W, 1'b1, 5'd8, 32'd0, 32'h0000_4004, 1'b0, 1'b0);
      step();
      bus.exe_to_mem_valid = 1'b0;
      @(negedge clk);
      tests_run++;
      if (dut.discard_cnt !== 2'd1 || bus.mem_rf_zip[38] !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL rw_pre: got cnt=%0d block=%0b expected 1/1", dut.discard_cnt, bus.mem_rf_zip[38]);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      tests_run++;
      if (dut.discard_cnt !== 2'd0 || bus.mem_allowin !== 1'b1 || bus.mem_to_wb_valid !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL rw_state: got cnt=%0d allowin=%0b valid=%0b expected 0/1/0",
                  dut.discard_cnt, bus.mem_allowin, bus.mem_to_wb_valid);
      end
      tests_run++;
      if (bus.mem_rf_zip !== 39'd0 || bus.mem_to_wb_zip !== '0 || bus.mem_ex !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL rw_outputs: got rf_zip=%h mem_ex=%0b expected zero outputs", bus.mem_rf_zip, bus.mem_ex);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_load_word();
      test_load_align();
      test_ld_buf();
      test_flush();
      test_back_to_back();
      test_reset_in_wait();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
